// File: rtl/transpose_buffer.sv
// Double-buffered element-matrix transposer: collects ROWS input words per bank
// and drains them as COLS column words, MSB-first and zero-padded.
module transpose_buffer #(
    parameter int WORD_W = 128,
    parameter int ELEM_W = 8,
    parameter int ROWS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              DI_valid,
    output logic              DI_ready,
    input  logic [WORD_W-1:0] DI,
    output logic              DO_valid,
    input  logic              DO_ready,
    output logic [WORD_W-1:0] DO,
    output logic              DO_last,
    output logic              busy
);

    localparam int COLS = WORD_W / ELEM_W;
    localparam int WCW  = $clog2(ROWS + 1);
    localparam int CCW  = $clog2(COLS);
    localparam int RIW  = $clog2(ROWS);

    logic [WORD_W-1:0] mem [2][ROWS];

    logic           wbank;
    logic           rbank;
    logic [WCW-1:0] wcnt;
    logic [CCW-1:0] ccnt;
    logic [1:0]     full;
    logic [WCW-1:0] fill [2];

    logic           accept;
    logic           xfer;
    logic           last_xfer;
    logic           complete;
    logic           flush_eff;
    logic           close_bank;
    logic [WCW-1:0] close_fill;

    assign DI_ready = !rst && !full[wbank];
    assign DO_valid = !rst && full[rbank];
    assign DO_last  = DO_valid && (ccnt == CCW'(COLS - 1));
    assign busy     = !rst && ((|full) || (wcnt != '0));

    assign accept    = DI_valid && DI_ready;
    assign xfer      = DO_valid && DO_ready;
    assign last_xfer = xfer && DO_last;
    assign complete  = accept && (wcnt == WCW'(ROWS - 1));

    // A beat that completes the block already closes it, so flush adds nothing then
    assign flush_eff  = flush && !full[wbank] && ((wcnt != '0) || accept) && !complete;
    assign close_bank = complete || flush_eff;
    assign close_fill = wcnt + WCW'(accept);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank][wcnt[RIW-1:0]] <= DI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            wcnt    <= '0;
            ccnt    <= '0;
            full    <= '0;
            fill[0] <= '0;
            fill[1] <= '0;
        end else begin
            if (close_bank) begin
                full[wbank] <= 1'b1;
                fill[wbank] <= close_fill;
                wbank       <= ~wbank;
                wcnt        <= '0;
            end else if (accept) begin
                wcnt <= wcnt + WCW'(1);
            end

            // Closing requires !full[wbank] and draining requires full[rbank],
            // so both updates never target the same bank in one cycle.
            if (last_xfer) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
                ccnt        <= '0;
            end else if (xfer) begin
                ccnt <= ccnt + CCW'(1);
            end
        end
    end

    always_comb begin
        DO = '0;
        if (DO_valid) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (r < 32'(fill[rbank])) begin
                    DO[WORD_W-1-r*ELEM_W -: ELEM_W] =
                        ELEM_W'(mem[rbank][RIW'(r)] >> (WORD_W - ELEM_W - 32'(ccnt) * ELEM_W));
                end
            end
        end
    end

endmodule
